// File: rtl/decode_cycle.sv
// RV32I decode stage: instruction decode, 32x32 register file, load-use detection, D->E register.
// Define REGFILE_BYPASS_EN for write-through of a same-cycle W-stage write to the read ports.
module decode_cycle #(
  parameter logic [31:0] REG_INIT = 32'h0000_0000,
  parameter logic [31:0] SP_INIT  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc_plus4_d,
  input  logic        reg_write_w,
  input  logic [4:0]  rd_w,
  input  logic [31:0] result_w,
  input  logic        flush_e,
  output logic        jal_d,
  output logic        jalr_d,
  output logic        branch_d,
  output logic        load_stall_d,
  output logic        reg_write_e,
  output logic        mem_read_e,
  output logic        mem_write_e,
  output logic        jal_e,
  output logic        jalr_e,
  output logic        branch_e,
  output logic        illegal_e,
  output logic [1:0]  result_src_e,
  output logic [1:0]  alu_src_a_e,
  output logic        alu_src_b_e,
  output logic [3:0]  alu_ctrl_e,
  output logic [2:0]  funct3_e,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_e,
  output logic [31:0] pc_e,
  output logic [31:0] pc_plus4_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011
  } opcode_t;

  logic [6:0]  opc;
  logic [2:0]  funct3;
  logic        f7b5;
  logic [4:0]  rs1, rs2, rd;

  assign opc    = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign f7b5   = instr_d[30];
  assign rs1    = instr_d[19:15];
  assign rs2    = instr_d[24:20];
  assign rd     = instr_d[11:7];

  logic        cRegWrite, cMemRead, cMemWrite, cJal, cJalr, cBranch, cIllegal;
  logic [1:0]  cResultSrc, cSrcA;
  logic        cSrcB;
  logic [3:0]  cAluCtrl;
  logic [31:0] imm;
  logic        usesRs1, usesRs2;

  always_comb begin
    cRegWrite  = 1'b0;
    cMemRead   = 1'b0;
    cMemWrite  = 1'b0;
    cJal       = 1'b0;
    cJalr      = 1'b0;
    cBranch    = 1'b0;
    cIllegal   = 1'b0;
    cResultSrc = 2'b00;
    cSrcA      = 2'b00;
    cSrcB      = 1'b0;
    cAluCtrl   = 4'b0000;
    imm        = '0;
    usesRs1    = 1'b1;
    usesRs2    = 1'b0;
    case (opc)
      OP_LUI: begin
        cRegWrite = 1'b1; cSrcA = 2'b10; cSrcB = 1'b1; usesRs1 = 1'b0;
        imm = {instr_d[31:12], 12'b0};
      end
      OP_AUIPC: begin
        cRegWrite = 1'b1; cSrcA = 2'b01; cSrcB = 1'b1; usesRs1 = 1'b0;
        imm = {instr_d[31:12], 12'b0};
      end
      OP_JAL: begin
        cRegWrite = 1'b1; cJal = 1'b1; cResultSrc = 2'b10; cSrcA = 2'b01; cSrcB = 1'b1;
        usesRs1 = 1'b0;
        imm = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
      end
      OP_JALR: begin
        cRegWrite = 1'b1; cJalr = 1'b1; cResultSrc = 2'b10; cSrcB = 1'b1;
        imm = {{20{instr_d[31]}}, instr_d[31:20]};
      end
      OP_BRANCH: begin
        cBranch = 1'b1; usesRs2 = 1'b1;
        imm = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
      end
      OP_LOAD: begin
        cRegWrite = 1'b1; cMemRead = 1'b1; cResultSrc = 2'b01; cSrcB = 1'b1;
        imm = {{20{instr_d[31]}}, instr_d[31:20]};
      end
      OP_STORE: begin
        cMemWrite = 1'b1; cSrcB = 1'b1; usesRs2 = 1'b1;
        imm = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      end
      OP_IMM: begin
        cRegWrite = 1'b1; cSrcB = 1'b1;
        // Only the shift-right group uses funct7[5]; elsewhere bit 30 is immediate data
        cAluCtrl = {(funct3 == 3'b101) & f7b5, funct3};
        imm = {{20{instr_d[31]}}, instr_d[31:20]};
      end
      OP_OP: begin
        cRegWrite = 1'b1; usesRs2 = 1'b1;
        cAluCtrl = {f7b5, funct3};
      end
      default: cIllegal = (instr_d != 32'h0);
    endcase
  end

  assign jal_d    = (opc == OP_JAL);
  assign jalr_d   = (opc == OP_JALR);
  assign branch_d = (opc == OP_BRANCH);

  assign load_stall_d = mem_read_e && (rd_e != 5'd0) &&
                        ((usesRs1 && (rs1 == rd_e)) || (usesRs2 && (rs2 == rd_e)));

  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++)
        regs[i] <= (i == 0) ? '0 : ((i == 2) ? SP_INIT : REG_INIT);
    end else if (reg_write_w && (rd_w != 5'd0)) begin
      regs[rd_w] <= result_w;
    end
  end

  logic [31:0] rd1, rd2;

  always_comb begin
    rd1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    rd2 = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef REGFILE_BYPASS_EN
    if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1)) rd1 = result_w;
    if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2)) rd2 = result_w;
`endif
  end

  logic bubble;
  assign bubble = flush_e || load_stall_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_e  <= 1'b0;
      mem_read_e   <= 1'b0;
      mem_write_e  <= 1'b0;
      jal_e        <= 1'b0;
      jalr_e       <= 1'b0;
      branch_e     <= 1'b0;
      illegal_e    <= 1'b0;
      result_src_e <= '0;
      alu_src_a_e  <= '0;
      alu_src_b_e  <= 1'b0;
      alu_ctrl_e   <= '0;
      funct3_e     <= '0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      imm_e        <= '0;
      pc_e         <= '0;
      pc_plus4_e   <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
    end else begin
      // Flush and stall share one bubble path: controls cleared, data fields still captured
      reg_write_e  <= bubble ? 1'b0  : cRegWrite;
      mem_read_e   <= bubble ? 1'b0  : cMemRead;
      mem_write_e  <= bubble ? 1'b0  : cMemWrite;
      jal_e        <= bubble ? 1'b0  : cJal;
      jalr_e       <= bubble ? 1'b0  : cJalr;
      branch_e     <= bubble ? 1'b0  : cBranch;
      illegal_e    <= bubble ? 1'b0  : cIllegal;
      result_src_e <= bubble ? 2'b00 : cResultSrc;
      alu_src_a_e  <= bubble ? 2'b00 : cSrcA;
      alu_src_b_e  <= bubble ? 1'b0  : cSrcB;
      alu_ctrl_e   <= bubble ? 4'b0  : cAluCtrl;
      funct3_e     <= funct3;
      rd1_e        <= rd1;
      rd2_e        <= rd2;
      imm_e        <= imm;
      pc_e         <= pc_d;
      pc_plus4_e   <= pc_plus4_d;
      rs1_e        <= rs1;
      rs2_e        <= rs2;
      rd_e         <= rd;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed-vector bench for decode_cycle with hand-computed expectations.
module tb_decode_cycle;

  localparam logic [31:0] REG_INIT_V = 32'h0000_0011;
  localparam logic [31:0] SP_INIT_V  = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d, pc_d, pc_plus4_d, result_w;
  logic        reg_write_w, flush_e;
  logic [4:0]  rd_w;
  logic        jal_d, jalr_d, branch_d, load_stall_d;
  logic        reg_write_e, mem_read_e, mem_write_e, jal_e, jalr_e, branch_e, illegal_e;
  logic [1:0]  result_src_e, alu_src_a_e;
  logic        alu_src_b_e;
  logic [3:0]  alu_ctrl_e;
  logic [2:0]  funct3_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  int nTests = 0;
  int nFails = 0;
  logic [31:0] pcNext = 32'h0000_0100;

  decode_cycle #(.REG_INIT(REG_INIT_V), .SP_INIT(SP_INIT_V)) dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w), .flush_e(flush_e),
    .jal_d(jal_d), .jalr_d(jalr_d), .branch_d(branch_d), .load_stall_d(load_stall_d),
    .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
    .jal_e(jal_e), .jalr_e(jalr_e), .branch_e(branch_e), .illegal_e(illegal_e),
    .result_src_e(result_src_e), .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e),
    .alu_ctrl_e(alu_ctrl_e), .funct3_e(funct3_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present an instruction in D, clock it into E, settle 1 time unit past the edge.
  task automatic issue(input logic [31:0] ins);
    instr_d    = ins;
    pc_d       = pcNext;
    pc_plus4_d = pcNext + 32'd4;
    pcNext     = pcNext + 32'd4;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctrlVec();
    return {17'b0, reg_write_e, mem_read_e, mem_write_e, jal_e, jalr_e, branch_e,
            illegal_e, result_src_e, alu_src_a_e, alu_src_b_e, alu_ctrl_e};
  endfunction

  initial begin
    rst = 1'b0; instr_d = '0; pc_d = '0; pc_plus4_d = '0;
    reg_write_w = 1'b0; rd_w = '0; result_w = '0; flush_e = 1'b0;
    #12;
    check("reset_ctrl", ctrlVec(), 32'h0);
    check("reset_imm", imm_e, 32'h0);
    check("reset_rd", {27'b0, rd_e}, 32'h0);
    rst = 1'b1;

    // addi x1,x0,-5
    issue(32'hFFB00093);
    check("addi_imm", imm_e, 32'hFFFFFFFB);
    check("addi_srcb", {31'b0, alu_src_b_e}, 32'h1);
    check("addi_regw", {31'b0, reg_write_e}, 32'h1);
    check("addi_rd", {27'b0, rd_e}, 32'd1);
    check("addi_pc", pc_e, 32'h0000_0100);
    check("addi_pc4", pc_plus4_e, 32'h0000_0104);
    check("addi_ill", {31'b0, illegal_e}, 32'h0);

    // lui x3,0x12345
    issue(32'h123451B7);
    check("lui_imm", imm_e, 32'h12345000);
    check("lui_srca", {30'b0, alu_src_a_e}, 32'h2);
    // sw x2,-4(x1)
    issue(32'hFE20AE23);
    check("sw_imm", imm_e, 32'hFFFFFFFC);
    check("sw_memw", {31'b0, mem_write_e}, 32'h1);
    check("sw_regw", {31'b0, reg_write_e}, 32'h0);
    // jal x1,-8
    instr_d = 32'hFF9FF0EF; #1;
    check("jal_d", {31'b0, jal_d}, 32'h1);
    issue(32'hFF9FF0EF);
    check("jal_imm", imm_e, 32'hFFFFFFF8);
    check("jal_e", {31'b0, jal_e}, 32'h1);
    check("jal_rsrc", {30'b0, result_src_e}, 32'h2);
    // srai x4,x1,3 / addi x4,x1,0x400 / sub x4,x1,x2
    issue(32'h4030D213);
    check("srai_alu", {28'b0, alu_ctrl_e}, 32'hD);
    issue(32'h40008213);
    check("addi_bit30_alu", {28'b0, alu_ctrl_e}, 32'h0);
    check("addi_bit30_imm", imm_e, 32'h00000400);
    issue(32'h40208233);
    check("sub_alu", {28'b0, alu_ctrl_e}, 32'h8);
    check("sub_srcb", {31'b0, alu_src_b_e}, 32'h0);

    // Load-use: lw x5,0(x1) then add x6,x5,x2
    issue(32'h0000A283);
    check("lw_memr", {31'b0, mem_read_e}, 32'h1);
    check("lw_rsrc", {30'b0, result_src_e}, 32'h1);
    instr_d = 32'h00228333; #1;
    check("stall_on", {31'b0, load_stall_d}, 32'h1);
    @(posedge clk); #1;
    check("stall_bubble", ctrlVec(), 32'h0);
    check("stall_off", {31'b0, load_stall_d}, 32'h0);
    @(posedge clk); #1;
    check("add_regw", {31'b0, reg_write_e}, 32'h1);
    check("add_rd", {27'b0, rd_e}, 32'd6);
    check("add_rs1", {27'b0, rs1_e}, 32'd5);
    check("add_rs2", {27'b0, rs2_e}, 32'd2);
    check("add_rd2", rd2_e, SP_INIT_V);

    // Load to x0 followed by add x6,x0,x2: no stall
    issue(32'h0000A003);
    instr_d = 32'h00200333; #1;
    check("stall_x0", {31'b0, load_stall_d}, 32'h0);
    @(posedge clk); #1;
    check("x0_add_regw", {31'b0, reg_write_e}, 32'h1);

    // W writes x7 while D reads x7 (add x8,x7,x0)
    reg_write_w = 1'b1; rd_w = 5'd7; result_w = 32'hDEADBEEF;
    issue(32'h00038433);
    reg_write_w = 1'b0;
`ifdef REGFILE_BYPASS_EN
    check("wr_rd_same", rd1_e, 32'hDEADBEEF);
`else
    check("wr_rd_same", rd1_e, REG_INIT_V);
`endif
    issue(32'h00038433);
    check("wr_then_rd", rd1_e, 32'hDEADBEEF);
    // Write to x0 ignored
    reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'h12345678;
    issue(32'h00000433);
    reg_write_w = 1'b0;
    issue(32'h00000433);
    check("x0_read", rd1_e, 32'h0);

    // beq x1,x2 without and with flush
    instr_d = 32'h00208063; #1;
    check("branch_d", {31'b0, branch_d}, 32'h1);
    issue(32'h00208063);
    check("beq_branch", {31'b0, branch_e}, 32'h1);
    flush_e = 1'b1;
    issue(32'h00208063);
    flush_e = 1'b0;
    check("flush_ctrl", ctrlVec(), 32'h0);
    check("flush_data_rs2", {27'b0, rs2_e}, 32'd2);
    issue(32'h00000000);
    check("zero_word", ctrlVec(), 32'h0);
    issue(32'hFFFFFFFF);
    check("illegal", {31'b0, illegal_e}, 32'h1);
    check("illegal_regw", {31'b0, reg_write_e}, 32'h0);
    // Flush must also clear illegal_e
    flush_e = 1'b1;
    issue(32'hFFFFFFFF);
    flush_e = 1'b0;
    check("flush_illegal", {31'b0, illegal_e}, 32'h0);
    issue(32'h4030D213);

    // Mid-run asynchronous reset, then read x2 and x7
    @(negedge clk);
    rst = 1'b0; #1;
    check("midreset_ctrl", ctrlVec(), 32'h0);
    check("midreset_pc", pc_e, 32'h0);
    check("midreset_rd", {27'b0, rd_e}, 32'h0);
    rst = 1'b1;
    issue(32'h00710033);
    check("sp_init", rd1_e, SP_INIT_V);
    check("x7_reinit", rd2_e, REG_INIT_V);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
